sig_shift_ctrl: RTL and testbench
=================================

// Module: sig_shift_ctrl
// PURPOSE
// - Sequencer for a serial shift/XOR-feedback register (LFSR/MISR-style signature datapath).
// - Loads a seed, feeds exactly N serial bits through the register under a valid/ready handshake,
//   captures the final state as a signature and reports completion.
// - Sits between a test/config master (start, seed, count) and a serial bit source (d stream).
// PARAMETERS
// - WIDTH  default 8      signature register width in bits, >= 2
// - TAPS   default 8'hB8  feedback tap mask, WIDTH bits; bit i set = state[i] feeds the XOR
// - CNT_W  default 8      width of the bit-count request; max run is 2**CNT_W-1 bits
// PORTS
// - clk      in   1      rising-edge clock
// - reset    in   1      asynchronous, active-high reset
// - start    in   1      request a run; sampled only in IDLE
// - seed     in   WIDTH  initial register value, sampled with start
// - nbits    in   CNT_W  number of serial bits to absorb, sampled with start
// - d_valid  in   1      serial bit d is valid this cycle
// - d        in   1      serial data bit
// - d_ready  out  1      controller accepts d this cycle
// - busy     out  1      run in progress (RUN or DONE state)
// - done     out  1      one-cycle completion pulse
// - sig      out  WIDTH  captured signature; held until the next completed run
// BEHAVIOUR
// - Reset (async, any state): FSM=IDLE, shift state=0, count=0, sig=0, d_ready=0, busy=0, done=0.
// - FSM states: IDLE, RUN, DONE. Outputs are Moore, decoded from the state register.
//   - d_ready=1 only in RUN.
//   - busy=1 in RUN and DONE.
//   - done=1 only in DONE.
// - IDLE with start=1:
//   - load shift state<=seed and count<=nbits.
//   - next state is RUN if nbits!=0, otherwise DONE.
// - IDLE with start=0: hold.
// - start outside IDLE is ignored. No queuing.
// - RUN: a beat is accepted when d_valid && d_ready.
//   - On accept: state <= {state[WIDTH-2:0], (^(state & TAPS)) ^ d} and count <= count-1.
//   - On the accept with count==1: next state is DONE.
// - RUN with d_valid=0: stall. State and count hold. No timeout.
// - DONE: sig <= shift state on the same edge DONE is entered, so sig is valid while done=1.
//   DONE lasts exactly one cycle, then returns to IDLE.
// - Latency:
//   - start sampled at edge k -> d_ready high in cycle k+1.
//   - last bit accepted at edge m -> done=1 and new sig in cycle m+1 -> IDLE at m+2.
//   - Minimum run (nbits=1, d_valid held high): start at k, done in cycle k+2.
//   - nbits=0: start at k, done in cycle k+1, sig==seed.
// - Back-to-back runs: start asserted during the DONE cycle is ignored.
//   The earliest new start is sampled in IDLE, one cycle after done.
// - sig changes only on entry to DONE or on reset. It holds through IDLE and during the next run.
// - Count arithmetic is unsigned CNT_W bits. No wrap is possible, because the decrement happens only while count>=1.
// - Reset asserted mid-run aborts: no done pulse, sig=0, and the bits already absorbed are lost.
// STRUCTURE
// - Shared package sig_shift_pkg:
//   - typedef enum {IDLE, RUN, DONE} sig_state_e.
//   - default WIDTH/TAPS/CNT_W constants.
// - Sub-module sig_shift_reg: WIDTH-bit register with async reset, sync load (seed) and
//   shift-enable, implementing the feedback rule above.
//   This is the generalised form of the team's 2-stage shift/XOR register.
// - sig_shift_ctrl holds the FSM, the bit counter, the sig capture register and the handshake decode.
// TESTING (WIDTH=8, TAPS=8'hB8, CNT_W=8)
// - Reset mid-RUN: all outputs 0 asynchronously, FSM back in IDLE; a following start works normally.
// - seed=8'h01, nbits=1, d=0, d_valid=1 -> done pulse in cycle k+2, sig=8'h02.
// - seed=8'h80, nbits=1, d=0 -> sig=8'h01. Same with d=1 -> sig=8'h00 (feedback XOR d cancels).
// - nbits=0, seed=8'h5A -> done in cycle k+1, sig=8'h5A, d_ready never asserts.
// - nbits=4, d_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats absorbed; sig matches a bench reference model;
//   done only after the 4th accept.
// - start pulsed during RUN and during DONE -> ignored; count/sig unaffected; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/sig_shift_pkg.sv
// Shared types and default geometry for the signature shift sequencer.
package sig_shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sig_state_e;

    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_TAPS  = 8'hB8;
    localparam int         DEF_CNT_W = 8;

endpackage

// File: rtl/sig_shift_ctrl_if.sv
// Request/serial-stream/status bundle between a config master and the sequencer.
interface sig_shift_ctrl_if
    import sig_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic             start;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] nbits;
    logic             d_valid;
    logic             d;
    logic             d_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sig;

    modport master (
        output start, seed, nbits, d_valid, d,
        input  d_ready, busy, done, sig
    );

    modport slave (
        input  start, seed, nbits, d_valid, d,
        output d_ready, busy, done, sig
    );

endinterface

// File: rtl/sig_shift_reg.sv
// Loadable shift register with XOR tap feedback mixed with a serial input bit.
module sig_shift_reg
    import sig_shift_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             shift_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] state_nxt_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    assign fb = (^(state_q & TAPS)) ^ d_i;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (shift_i) begin
            state_d = {state_q[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state is exported so the controller can capture the signature on the same edge.
    assign state_nxt_o = state_d;

endmodule

// File: rtl/sig_shift_ctrl.sv
// Run sequencer: seeds the shift register, absorbs nbits serial beats, latches the signature.
module sig_shift_ctrl
    import sig_shift_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter int               CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    sig_shift_ctrl_if.slave   bus
);

    sig_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] shift_nxt;
    logic             load;
    logic             accept;

    assign accept = (state_q == RUN) && bus.d_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = bus.nbits;
                    state_d = (bus.nbits != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Entry into DONE is the only time the signature moves.
            if (state_d == DONE) begin
                sig_q <= shift_nxt;
            end
        end
    end

    sig_shift_reg #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_reg (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .seed_i      (bus.seed),
        .shift_i     (accept),
        .d_i         (bus.d),
        .state_nxt_o (shift_nxt)
    );

    assign bus.d_ready = (state_q == RUN);
    assign bus.busy    = (state_q == RUN) || (state_q == DONE);
    assign bus.done    = (state_q == DONE);
    assign bus.sig     = sig_q;

endmodule

// File: tb/tb_sig_shift_ctrl.sv
// Directed bench for the signature shift sequencer (WIDTH=8, TAPS=B8, CNT_W=8).
module tb_sig_shift_ctrl;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    sig_shift_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

    sig_shift_ctrl #(.WIDTH(8), .TAPS(8'hB8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seed;
        logic [7:0] nbits;
        logic [7:0] bits;     // bit i is fed on beat i
        logic [7:0] exp_sig;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (act === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] s, input logic din);
        return {s[6:0], (^(s & 8'hB8)) ^ din};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Valid held high; checks latency, beat count, signature and the return to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int   edges;
        int   beat;
        logic acc;
        bus.start   = 1'b1;
        bus.seed    = v.seed;
        bus.nbits   = v.nbits;
        bus.d_valid = 1'b1;
        bus.d       = v.bits[0];
        beat        = 0;
        tick();
        bus.start = 1'b0;
        edges     = 1;
        while (!bus.done && edges < 300) begin
            acc = bus.d_ready && bus.d_valid;
            tick();
            edges++;
            if (acc) begin
                beat++;
                bus.d = v.bits[beat[2:0]];
            end
        end
        check({tag, "_done"},    32'(bus.done),    32'd1);
        check({tag, "_latency"}, 32'(edges),       32'(v.nbits) + 32'd1);
        check({tag, "_beats"},   32'(beat),        32'(v.nbits));
        check({tag, "_sig"},     32'(bus.sig),     32'(v.exp_sig));
        check({tag, "_busy"},    32'(bus.busy),    32'd1);
        check({tag, "_rdy_dn"},  32'(bus.d_ready), 32'd0);
        bus.d_valid = 1'b0;
        tick();
        check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_sig"},  32'(bus.sig),  32'(v.exp_sig));
    endtask

    initial begin
        logic [7:0] s_ref;
        logic [7:0] bits4;
        logic [6:0] vpat;
        logic       acc;
        int         beat;

        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{seed: 8'h01, nbits: 8'd1, bits: 8'h00, exp_sig: 8'h02};
        vecs[1] = '{seed: 8'h80, nbits: 8'd1, bits: 8'h00, exp_sig: 8'h01};
        vecs[2] = '{seed: 8'h80, nbits: 8'd1, bits: 8'h01, exp_sig: 8'h00};
        vecs[3] = '{seed: 8'h5A, nbits: 8'd0, bits: 8'h00, exp_sig: 8'h5A};
        vecs[4] = '{seed: 8'hFF, nbits: 8'd2, bits: 8'h00, exp_sig: 8'hFC};
        vecs[5] = '{seed: 8'h00, nbits: 8'd3, bits: 8'h07, exp_sig: 8'h07};

        bus.start   = 1'b0;
        bus.seed    = '0;
        bus.nbits   = '0;
        bus.d_valid = 1'b0;
        bus.d       = 1'b0;
        reset       = 1'b1;
        #12;
        check("rst_ready", 32'(bus.d_ready), 32'd0);
        check("rst_busy",  32'(bus.busy),    32'd0);
        check("rst_done",  32'(bus.done),    32'd0);
        check("rst_sig",   32'(bus.sig),     32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // nbits=4 with a gapped valid pattern, plus stray starts in RUN and DONE.
        bits4 = 8'b0000_1101;
        vpat  = 7'b1011001;   // applied LSB first: 1,0,0,1,1,0,1
        s_ref = 8'h3C;
        for (int i = 0; i < 4; i++) s_ref = step(s_ref, bits4[i]);
        bus.start = 1'b1;
        bus.seed  = 8'h3C;
        bus.nbits = 8'd4;
        tick();
        bus.start = 1'b0;
        check("gap_ready", 32'(bus.d_ready), 32'd1);
        beat = 0;
        for (int j = 0; j < 7; j++) begin
            bus.d_valid = vpat[j];
            bus.d       = bits4[beat[2:0]];
            if (j == 1) begin
                bus.start = 1'b1;
                bus.seed  = 8'hEE;
                bus.nbits = 8'd9;
            end
            acc = bus.d_ready && bus.d_valid;
            tick();
            bus.start = 1'b0;
            if (acc) beat++;
            check($sformatf("gap_done_j%0d", j), 32'(bus.done), (beat == 4) ? 32'd1 : 32'd0);
        end
        check("gap_beats", 32'(beat),    32'd4);
        check("gap_sig",   32'(bus.sig), 32'(s_ref));
        bus.d_valid = 1'b0;
        bus.start   = 1'b1;
        bus.seed    = 8'h77;
        bus.nbits   = 8'd0;
        tick();
        bus.start = 1'b0;
        check("dstart_done", 32'(bus.done), 32'd0);
        check("dstart_busy", 32'(bus.busy), 32'd0);
        tick();
        check("dstart_done2", 32'(bus.done), 32'd0);
        check("dstart_busy2", 32'(bus.busy), 32'd0);
        check("dstart_sig",   32'(bus.sig),  32'(s_ref));

        // Abort a run with reset; sig must hold during the run and clear on reset.
        bus.start   = 1'b1;
        bus.seed    = 8'hAA;
        bus.nbits   = 8'd5;
        bus.d_valid = 1'b1;
        bus.d       = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("abort_busy_pre", 32'(bus.busy), 32'd1);
        check("abort_sig_hold", 32'(bus.sig),  32'(s_ref));
        #2;
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(bus.d_ready), 32'd0);
        check("abort_busy",  32'(bus.busy),    32'd0);
        check("abort_done",  32'(bus.done),    32'd0);
        check("abort_sig",   32'(bus.sig),     32'd0);
        tick();
        reset       = 1'b0;
        bus.d_valid = 1'b0;
        tick();
        check("post_abort_idle", 32'(bus.busy), 32'd0);
        run_vec(vecs[0], "post_abort");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
